// File: rtl/sparse_decomp_scheduler_pkg.sv
// sparse_sched_pkg: shared state type, block geometry and mask helper for the
// sparse decompressor scheduler.
package sparse_sched_pkg;
  typedef enum logic {IDLE, BURST} state_e;
  localparam int MASK_W = 4;
  localparam int PACK_N = 2;
  function automatic logic [2:0] popcount4(input logic [MASK_W-1:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction
endpackage

// File: rtl/sparse_decomp_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping cyclically.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          any_req
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt = '0;
    idx = '0;
    // Scan from farthest to nearest so the nearest hit overwrites the rest.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) gnt = idx;
    end
    any_req = |req;
  end
endmodule

// File: rtl/sparse_decomp_scheduler.sv
// sparse_decomp_scheduler: round-robin burst-locked arbiter feeding one 2:4 sparse decompressor.
// Define SPARSE_MASK_CHECK_EN to zero and flag masks with more than two set bits.
module sparse_decomp_scheduler
  import sparse_sched_pkg::*;
#(
  parameter int W = 16,
  parameter int NREQ = 4,
  parameter int MAXBURST = 64,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          blk_valid,
  output logic [NREQ-1:0]          blk_ready,
  input  logic [NREQ*PACK_N*W-1:0] blk_vals,
  input  logic [NREQ*MASK_W-1:0]   blk_mask,
  input  logic [NREQ-1:0]          blk_last,
  input  logic                     dn_ready,
  output logic                     dec_valid,
  output logic [PACK_N*W-1:0]      dec_vals,
  output logic [MASK_W-1:0]        dec_mask,
  output logic                     tag_valid,
  output logic [IDW-1:0]           tag_id,
  output logic                     tag_last,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic [NREQ-1:0]          err_mask,
  output logic [NREQ-1:0]          err_burst
);
  localparam int CW = $clog2(MAXBURST) + 1;
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, grant_q, grant_d, tag_id_q, tag_id_d, arb_idx, nxt_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tag_valid_q, tag_valid_d, tag_last_q, tag_last_d;
  logic [NREQ-1:0] err_mask_q, err_mask_d, err_burst_q, err_burst_d;
  logic any_req, issue, last, cap, done, bad, start;
  logic [PACK_N*W-1:0] sel_vals;
  logic [MASK_W-1:0] sel_mask;

  rr_arbiter #(.N(NREQ)) u_arb (.req(blk_valid), .ptr(ptr_q), .gnt(arb_idx), .any_req(any_req));

  always_comb begin
    sel_vals = blk_vals[int'(grant_q)*PACK_N*W +: PACK_N*W];
    sel_mask = blk_mask[int'(grant_q)*MASK_W +: MASK_W];
    last = blk_last[grant_q];
    busy = state_q == BURST;
    start = !busy && any_req;
    issue = busy && blk_valid[grant_q] && dn_ready;
    cap = issue && !last && (cnt_q == CW'(MAXBURST - 1));
    done = issue && (last || cap);
`ifdef SPARSE_MASK_CHECK_EN
    bad = popcount4(sel_mask) > 3'd2;
    err_mask_d = err_mask_q | ((issue && bad) ? NREQ'(1) << grant_q : '0);
`else
    bad = 1'b0;
    err_mask_d = '0;
`endif
    nxt_idx = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    blk_ready = busy ? NREQ'(dn_ready) << grant_q : '0;
    dec_valid = issue;
    dec_vals = issue ? sel_vals : '0;
    dec_mask = (issue && !bad) ? sel_mask : '0;
    state_d = done ? IDLE : start ? BURST : state_q;
    grant_d = start ? arb_idx : grant_q;
    cnt_d = !busy ? '0 : issue ? cnt_q + 1'b1 : cnt_q;
    ptr_d = done ? nxt_idx : ptr_q;
    // Tags trail issue by one cycle to line up with the decompressor's output register.
    tag_valid_d = issue;
    tag_id_d = issue ? grant_q : '0;
    tag_last_d = done;
    err_burst_d = err_burst_q | (cap ? NREQ'(1) << grant_q : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      cnt_q <= '0;
      tag_valid_q <= 1'b0;
      tag_id_q <= '0;
      tag_last_q <= 1'b0;
      err_mask_q <= '0;
      err_burst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q <= tag_id_d;
      tag_last_q <= tag_last_d;
      err_mask_q <= err_mask_d;
      err_burst_q <= err_burst_d;
    end
  end

  assign grant_id = grant_q;
  assign tag_valid = tag_valid_q;
  assign tag_id = tag_id_q;
  assign tag_last = tag_last_q;
  assign err_mask = err_mask_q;
  assign err_burst = err_burst_q;
endmodule

// File: tb/tb_sparse_decomp_scheduler.sv
// tb_sparse_decomp_scheduler: directed checks of arbitration, stalls, forced release,
// mask checking and reset for sparse_decomp_scheduler (built with MAXBURST = 4).
module tb_sparse_decomp_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] blk_valid = '0, blk_ready, blk_last = '0, err_mask, err_burst;
  logic [127:0] blk_vals = '0;
  logic [15:0] blk_mask = '0;
  logic dn_ready = 1'b0, dec_valid, tag_valid, tag_last, busy;
  logic [31:0] dec_vals;
  logic [3:0] dec_mask;
  logic [1:0] tag_id, grant_id;
  int n = 0, f = 0;
`ifdef SPARSE_MASK_CHECK_EN
  localparam logic [3:0] EXP_M = 4'b0000, EXP_E = 4'b1000;
`else
  localparam logic [3:0] EXP_M = 4'b0111, EXP_E = 4'b0000;
`endif

  sparse_decomp_scheduler #(.W(16), .NREQ(4), .MAXBURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_vals(blk_vals), .blk_mask(blk_mask), .blk_last(blk_last), .dn_ready(dn_ready),
    .dec_valid(dec_valid), .dec_vals(dec_vals), .dec_mask(dec_mask), .tag_valid(tag_valid),
    .tag_id(tag_id), .tag_last(tag_last), .grant_id(grant_id), .busy(busy),
    .err_mask(err_mask), .err_burst(err_burst)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_blk(input int i, input logic [31:0] v, input logic [3:0] m, input logic l);
    blk_vals[i*32 +: 32] = v;
    blk_mask[i*4 +: 4] = m;
    blk_last[i] = l;
  endtask

  task automatic do_reset();
    blk_valid = '0;
    blk_vals = '0;
    blk_mask = '0;
    blk_last = '0;
    dn_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n++;
    if ({blk_ready, dec_valid, dec_vals, dec_mask, tag_valid, tag_id, tag_last, grant_id, busy, err_mask, err_burst} !== '0) begin
      f++;
      $display("FAIL reset_outputs got ready=%b dv=%b tv=%b gid=%0d busy=%b em=%b eb=%b want all 0",
               blk_ready, dec_valid, tag_valid, grant_id, busy, err_mask, err_burst);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    set_blk(0, 32'hAAAABBBB, 4'b0101, 1'b0);
    blk_valid = 4'b0001;
    dn_ready = 1'b1;
    #1;
    n++;
    if ({busy, blk_ready, dec_valid} !== 6'b0) begin
      f++;
      $display("FAIL idle_no_accept got busy=%b ready=%b dv=%b want 0 0000 0", busy, blk_ready, dec_valid);
    end
    tick();
    n++;
    if ({busy, grant_id, blk_ready, dec_valid, dec_vals, dec_mask, tag_valid} !== {1'b1, 2'd0, 4'b0001, 1'b1, 32'hAAAABBBB, 4'b0101, 1'b0}) begin
      f++;
      $display("FAIL burst_blk1 got busy=%b gid=%0d ready=%b dv=%b vals=%h mask=%b tv=%b", busy, grant_id, blk_ready, dec_valid, dec_vals, dec_mask, tag_valid);
    end
    tick();
    set_blk(0, 32'h11112222, 4'b0011, 1'b0);
    #1;
    n++;
    if ({dec_valid, dec_vals, dec_mask, tag_valid, tag_id, tag_last} !== {1'b1, 32'h11112222, 4'b0011, 1'b1, 2'd0, 1'b0}) begin
      f++;
      $display("FAIL burst_blk2 got dv=%b vals=%h mask=%b tag=%b/%0d/%b", dec_valid, dec_vals, dec_mask, tag_valid, tag_id, tag_last);
    end
    tick();
    set_blk(0, 32'h33334444, 4'b1100, 1'b1);
    #1;
    n++;
    if ({dec_valid, tag_valid, tag_id, tag_last} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin
      f++;
      $display("FAIL burst_blk3 got dv=%b tag=%b/%0d/%b want 1 tag=1/0/0", dec_valid, tag_valid, tag_id, tag_last);
    end
    tick();
    blk_valid = 4'b0011;
    set_blk(1, 32'h55556666, 4'b1001, 1'b1);
    #1;
    n++;
    if ({busy, dec_valid, tag_valid, tag_id, tag_last} !== {1'b0, 1'b0, 1'b1, 2'd0, 1'b1}) begin
      f++;
      $display("FAIL burst_end got busy=%b dv=%b tag=%b/%0d/%b want 0 0 tag=1/0/1", busy, dec_valid, tag_valid, tag_id, tag_last);
    end
    tick();
    n++;
    if ({busy, grant_id, tag_valid} !== {1'b1, 2'd1, 1'b0}) begin
      f++;
      $display("FAIL pointer_advance got busy=%b gid=%0d tv=%b want 1 1 0", busy, grant_id, tag_valid);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] g;
    logic b;
    do_reset();
    set_blk(0, 32'h0000000A, 4'b0001, 1'b1);
    set_blk(2, 32'h0000000C, 4'b0010, 1'b1);
    blk_valid = 4'b0101;
    dn_ready = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      g = (((k - 1) / 2) % 2 == 1) ? 2'd2 : 2'd0;
      b = (k % 2 == 1);
      n++;
      if ({busy, grant_id, dec_valid, tag_valid} !== {b, g, b, !b}) begin
        f++;
        $display("FAIL alternate_k%0d got busy=%b gid=%0d dv=%b tv=%b want %b %0d %b %b", k, busy, grant_id, dec_valid, tag_valid, b, g, b, !b);
      end
      if (!b) begin
        n++;
        if ({tag_id, tag_last} !== {g, 1'b1}) begin
          f++;
          $display("FAIL alternate_tag_k%0d got id=%0d last=%b want %0d 1", k, tag_id, tag_last, g);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_blk(1, 32'hA0A0B0B0, 4'b0101, 1'b0);
    blk_valid = 4'b0010;
    dn_ready = 1'b1;
    #1;
    tick();
    n++;
    if ({busy, grant_id, blk_ready, dec_valid, dec_vals, dec_mask} !== {1'b1, 2'd1, 4'b0010, 1'b1, 32'hA0A0B0B0, 4'b0101}) begin
      f++;
      $display("FAIL stall_first got busy=%b gid=%0d ready=%b dv=%b vals=%h mask=%b", busy, grant_id, blk_ready, dec_valid, dec_vals, dec_mask);
    end
    tick();
    set_blk(1, 32'hC0C0D0D0, 4'b1010, 1'b0);
    dn_ready = 1'b0;
    #1;
    n++;
    if ({blk_ready, dec_valid, dec_vals, dec_mask, tag_valid, tag_last} !== {4'b0, 1'b0, 32'h0, 4'b0, 1'b1, 1'b0}) begin
      f++;
      $display("FAIL stall_hold1 got ready=%b dv=%b vals=%h mask=%b tv=%b tl=%b", blk_ready, dec_valid, dec_vals, dec_mask, tag_valid, tag_last);
    end
    tick();
    n++;
    if ({blk_ready, dec_valid, tag_valid, busy} !== {4'b0, 1'b0, 1'b0, 1'b1}) begin
      f++;
      $display("FAIL stall_hold2 got ready=%b dv=%b tv=%b busy=%b want 0000 0 0 1", blk_ready, dec_valid, tag_valid, busy);
    end
    tick();
    dn_ready = 1'b1;
    set_blk(1, 32'hC0C0D0D0, 4'b1010, 1'b1);
    #1;
    n++;
    if ({blk_ready, dec_valid, dec_vals, dec_mask, tag_valid} !== {4'b0010, 1'b1, 32'hC0C0D0D0, 4'b1010, 1'b0}) begin
      f++;
      $display("FAIL stall_resume got ready=%b dv=%b vals=%h mask=%b tv=%b", blk_ready, dec_valid, dec_vals, dec_mask, tag_valid);
    end
    tick();
    blk_valid = 4'b0;
    #1;
    n++;
    if ({busy, tag_valid, tag_id, tag_last} !== {1'b0, 1'b1, 2'd1, 1'b1}) begin
      f++;
      $display("FAIL stall_last got busy=%b tag=%b/%0d/%b want 0 tag=1/1/1", busy, tag_valid, tag_id, tag_last);
    end
  endtask

  task automatic test_forced_release();
    do_reset();
    set_blk(1, 32'h12345678, 4'b0011, 1'b0);
    set_blk(2, 32'h9ABCDEF0, 4'b0110, 1'b0);
    blk_valid = 4'b0110;
    dn_ready = 1'b1;
    #1;
    tick();
    n++;
    if ({busy, grant_id} !== {1'b1, 2'd1}) begin
      f++;
      $display("FAIL forced_grant got busy=%b gid=%0d want 1 1", busy, grant_id);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      n++;
      if ({tag_valid, tag_id, tag_last, err_burst} !== {1'b1, 2'd1, 1'b0, 4'b0}) begin
        f++;
        $display("FAIL forced_mid_k%0d got tag=%b/%0d/%b eb=%b want 1/1/0 0000", k, tag_valid, tag_id, tag_last, err_burst);
      end
    end
    tick();
    n++;
    if ({busy, tag_valid, tag_id, tag_last, err_burst} !== {1'b0, 1'b1, 2'd1, 1'b1, 4'b0010}) begin
      f++;
      $display("FAIL forced_release got busy=%b tag=%b/%0d/%b eb=%b want 0 1/1/1 0010", busy, tag_valid, tag_id, tag_last, err_burst);
    end
    tick();
    n++;
    if ({busy, grant_id, err_burst} !== {1'b1, 2'd2, 4'b0010}) begin
      f++;
      $display("FAIL forced_next got busy=%b gid=%0d eb=%b want 1 2 0010", busy, grant_id, err_burst);
    end
  endtask

  task automatic test_reset_mid_burst();
    rst_n = 1'b0;
    tick();
    n++;
    if ({blk_ready, dec_valid, dec_vals, dec_mask, tag_valid, tag_id, tag_last, grant_id, busy, err_mask, err_burst} !== '0) begin
      f++;
      $display("FAIL midreset_outputs got ready=%b dv=%b tv=%b gid=%0d busy=%b em=%b eb=%b want all 0",
               blk_ready, dec_valid, tag_valid, grant_id, busy, err_mask, err_burst);
    end
    rst_n = 1'b1;
    set_blk(1, 32'h0F0F0F0F, 4'b1001, 1'b1);
    #1;
    tick();
    n++;
    if ({busy, grant_id, tag_valid} !== {1'b1, 2'd1, 1'b0}) begin
      f++;
      $display("FAIL midreset_rearb got busy=%b gid=%0d tv=%b want 1 1 0", busy, grant_id, tag_valid);
    end
    tick();
    n++;
    if ({tag_valid, tag_id, tag_last, err_burst} !== {1'b1, 2'd1, 1'b1, 4'b0}) begin
      f++;
      $display("FAIL midreset_tag got tag=%b/%0d/%b eb=%b want 1/1/1 0000", tag_valid, tag_id, tag_last, err_burst);
    end
  endtask

  task automatic test_mask_check();
    do_reset();
    set_blk(3, 32'hFACE0BAD, 4'b0111, 1'b1);
    blk_valid = 4'b1000;
    dn_ready = 1'b1;
    #1;
    tick();
    n++;
    if ({dec_valid, dec_vals, dec_mask} !== {1'b1, 32'hFACE0BAD, EXP_M}) begin
      f++;
      $display("FAIL mask_issue got dv=%b vals=%h mask=%b want 1 face0bad %b", dec_valid, dec_vals, dec_mask, EXP_M);
    end
    tick();
    n++;
    if ({tag_valid, tag_id, tag_last, err_mask} !== {1'b1, 2'd3, 1'b1, EXP_E}) begin
      f++;
      $display("FAIL mask_tag got tag=%b/%0d/%b em=%b want 1/3/1 %b", tag_valid, tag_id, tag_last, err_mask, EXP_E);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_alternate();
    test_stall();
    test_forced_release();
    test_reset_mid_burst();
    test_mask_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n, f);
    $finish;
  end
endmodule
